n64_cmd_rx: RTL and testbench
=============================

# n64_cmd_rx

Console-side command receiver for the GameCube-to-N64 adapter. It samples the bidirectional N64 data line and decodes the console's pulse-width-coded command frames (command byte, plus address and data bytes for pak accesses). It then presents the 5-bit `Response` code that selects which reply frame the controller-response transmitter shifts out. While that reply is on the wire, the block holds the code stable and ignores the line.

## Interface

Parameters:
- `CLKS_PER_US`, 48: `clk` cycles per microsecond. The pico-ice build uses 48; other boards override it.
- `ONE_MAX_US`, 2: a low pulse shorter than this decodes as 1; a pulse of this length or longer decodes as 0.
- `LOW_MAX_US`, 5: a low pulse of this length or longer is a frame error.
- `IDLE_US`, 4: the line held high for this long ends the frame.
- `WDOG_US`, 500: maximum time `Response` is held without the transmitter becoming busy.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-high.
- `n64_in`, in, 1: raw N64 data line; asynchronous to `clk`.
- `tx_busy`, in, 1: high while the transmitter is shifting a reply.
- `Response`, out, 5: reply select code; `5'b00000` means idle.
- `cmd`, out, 8: last valid command byte.
- `pak_addr`, out, 16: address word of the last pak command, raw (11-bit address plus 5-bit CRC).
- `frame_err`, out, 1: one-cycle pulse when a frame is discarded.

## Operation

Input conditioning:
- `n64_in` passes through a 2-flop synchronizer, then a falling/rising edge detector on the synchronized value.

Bit decode:
- A falling edge starts the low-width counter.
- On the rising edge, the measured low width selects the bit: below `ONE_MAX_US*CLKS_PER_US` shifts in 1, otherwise 0.
- Bits shift MSB-first into the command, address and data fields, and `bitcnt` increments.
- The console stop bit (1 µs low) decodes as a trailing 1, so a valid frame has 8n+1 bits.

States:
- IDLE: wait for a falling edge, then go to RX.
- RX: decode bits.
  - Low width reaches `LOW_MAX_US`, or `bitcnt` exceeds 281: go to ERR.
  - Line high for `IDLE_US` since the last rising edge: classify the frame.
- Classification:
  - `bitcnt`=9 with command 0x00 or 0xFF: `Response`=10010.
  - `bitcnt`=9 with command 0x01: `Response`=10001.
  - `bitcnt`=25 with command 0x02, `pak_addr[15:5]`=0x400 (address 0x8000): `Response`=10101.
  - `bitcnt`=25 with any other command-0x02 address: `Response`=10110.
  - `bitcnt`=281 with command 0x03: `Response`=10111.
  - Any other count/command combination: go to ERR.
  - On success, latch `cmd` and `pak_addr`, then go to HOLD.
- HOLD: `Response` is stable and line edges are ignored, because the block's own reply is on the wire.
  - Leave HOLD when `tx_busy` has been seen high and then falls, or when `WDOG_US` expires. Either way, clear `Response` to 0 and go to IDLE.
- ERR: pulse `frame_err` once, then wait for `IDLE_US` of continuous high and go to IDLE. `Response` stays 0.

Write data:
- Write-pak data bytes are counted but not stored. Only the first 16 bits after the command are kept, as `pak_addr`.

## Timing

- Reset values: `Response`=0, `cmd`=0, `pak_addr`=0, `frame_err`=0, state IDLE, all counters 0.
- Synchronizer latency is 2 cycles. Edge detection adds 1 cycle.
- `Response` becomes valid in the cycle after the idle counter reaches `IDLE_US*CLKS_PER_US - 1`. This counter restarts on each rising edge.
- Width comparisons use the full counter value. Counters are sized with `$clog2(WDOG_US*CLKS_PER_US+1)` and saturate; they never wrap.
- A falling edge in the same cycle as idle expiry: idle expiry wins. The frame closes; the edge is discarded if the block moves to HOLD, or restarts RX if the block moves to ERR and then IDLE.
- `tx_busy` already high on entry to HOLD counts as "seen high".
- `reset` asserted at any point, mid-frame or in HOLD, returns the block to IDLE with reset values on the next edge.

## Structure

Shared package `n64_pkg` holds:
- Command constants: `CMD_STATUS`=0x00, `CMD_POLL`=0x01, `CMD_RDPAK`=0x02, `CMD_WRPAK`=0x03, `CMD_RESET`=0xFF.
- The 5-bit `Response` codes, shared with the transmitter.
- Frame bit counts: 9, 25 and 281.

One sub-module, `n64_bit_sampler`, contains the synchronizer, edge detection and low-width measurement. It outputs `bit_valid`, `bit_val`, `low_too_long` and `idle_hit`. The FSM and field shift registers stay in `n64_cmd_rx`.

## Test plan

All scenarios use `CLKS_PER_US`=48.
- Poll: command 0x01 plus stop bit, 1 µs/3 µs encoding → `Response`=10001 within 4 µs + 3 cycles of the last rising edge, `cmd`=0x01.
- Read pak at 0x8000: bytes 0x02, 0x80, 0x01 plus stop → `pak_addr`=0x8001, `Response`=10101. Pulsing `tx_busy` high for 100 µs then low → `Response`=0 one cycle later.
- Write pak: 0x03, 0xC0, 0x1B, 32 bytes of 0x80, stop → `Response`=10111, `pak_addr`=0xC01B. Toggles on `n64_in` during HOLD leave `Response` unchanged.
- Malformed frames:
  - 0x01 with a 6 µs low pulse → `frame_err` pulses once, `Response` stays 0, and the next valid 0xFF frame yields 10010.
  - 12-bit frame → `frame_err` pulses once, `Response` stays 0.
- Watchdog: after a status command with `tx_busy` held low → `Response` clears after 500 µs.
- Reset: `reset` asserted after 5 bits of a 0x02 frame → all outputs 0. A subsequent clean 0x00 frame → 10010.

Source files
------------

// File: rtl/n64_pkg.sv
// Shared definitions for the N64 console-side command receiver and reply transmitter:
// command bytes, reply-select codes, frame lengths and the frame classifier.
package n64_pkg;

    localparam logic [7:0] CMD_STATUS = 8'h00;
    localparam logic [7:0] CMD_POLL   = 8'h01;
    localparam logic [7:0] CMD_RDPAK  = 8'h02;
    localparam logic [7:0] CMD_WRPAK  = 8'h03;
    localparam logic [7:0] CMD_RESET  = 8'hFF;

    localparam logic [4:0] RESP_IDLE     = 5'b00000;
    localparam logic [4:0] RESP_STATUS   = 5'b10010;
    localparam logic [4:0] RESP_POLL     = 5'b10001;
    localparam logic [4:0] RESP_PAK_ID   = 5'b10101;
    localparam logic [4:0] RESP_RDPAK    = 5'b10110;
    localparam logic [4:0] RESP_WRPAK    = 5'b10111;

    // Frame lengths include the trailing console stop bit.
    localparam logic [8:0] BITS_SHORT = 9'd9;
    localparam logic [8:0] BITS_RDPAK = 9'd25;
    localparam logic [8:0] BITS_WRPAK = 9'd281;

    // Address bits [15:5] of the pak identification read (address 0x8000).
    localparam logic [10:0] PAK_ID_ADDR = 11'h400;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RX   = 2'd1,
        ST_HOLD = 2'd2,
        ST_ERR  = 2'd3
    } rx_state_t;

    // Maps a completed frame to its reply code; RESP_IDLE marks a frame to discard.
    function automatic logic [4:0] classify(input logic [8:0]  nbits,
                                            input logic [7:0]  cmd_byte,
                                            input logic [10:0] addr_hi);
        logic [4:0] r;
        r = RESP_IDLE;
        case (nbits)
            BITS_SHORT: begin
                if ((cmd_byte == CMD_STATUS) || (cmd_byte == CMD_RESET)) begin
                    r = RESP_STATUS;
                end else if (cmd_byte == CMD_POLL) begin
                    r = RESP_POLL;
                end else begin
                    r = RESP_IDLE;
                end
            end
            BITS_RDPAK: begin
                if (cmd_byte == CMD_RDPAK) begin
                    r = (addr_hi == PAK_ID_ADDR) ? RESP_PAK_ID : RESP_RDPAK;
                end else begin
                    r = RESP_IDLE;
                end
            end
            BITS_WRPAK: begin
                r = (cmd_byte == CMD_WRPAK) ? RESP_WRPAK : RESP_IDLE;
            end
            default: r = RESP_IDLE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/n64_cmd_rx_sampler.sv
// Line front end: synchronizes the N64 data line, detects edges and turns each
// low pulse into a decoded bit; also flags over-long lows and idle line time.
module n64_bit_sampler #(
    parameter int CLKS_PER_US = 48,
    parameter int ONE_MAX_US  = 2,
    parameter int LOW_MAX_US  = 5,
    parameter int IDLE_US     = 4,
    parameter int CW          = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic n64_in,
    output logic fall_edge,
    output logic bit_valid,
    output logic bit_val,
    output logic low_too_long,
    output logic idle_hit
);

    localparam logic [CW-1:0] ONE_TICKS = CW'(ONE_MAX_US * CLKS_PER_US);
    localparam logic [CW-1:0] LOW_TICKS = CW'(LOW_MAX_US * CLKS_PER_US);
    localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_US * CLKS_PER_US - 1);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};

    logic          sync1_r, sync2_r, prev_r;
    logic          fall_r, rise_r, bit_val_r;
    logic [CW-1:0] low_cnt_r, idle_cnt_r;
    logic          fall_s, rise_s;

    assign fall_s = prev_r & ~sync2_r;
    assign rise_s = ~prev_r & sync2_r;

    // Synchronizer chain (reset to the idle-high level) and registered edge/bit strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r   <= 1'b1;
            sync2_r   <= 1'b1;
            prev_r    <= 1'b1;
            fall_r    <= 1'b0;
            rise_r    <= 1'b0;
            bit_val_r <= 1'b0;
        end else begin
            sync1_r   <= n64_in;
            sync2_r   <= sync1_r;
            prev_r    <= sync2_r;
            fall_r    <= fall_s;
            rise_r    <= rise_s;
            bit_val_r <= rise_s ? (low_cnt_r < ONE_TICKS) : bit_val_r;
        end
    end

    // Saturating low-width and high-time counters; low width is held through the rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            low_cnt_r  <= CNT_ZERO;
            idle_cnt_r <= CNT_ZERO;
        end else if (!sync2_r) begin
            idle_cnt_r <= CNT_ZERO;
            if (fall_s) begin
                low_cnt_r <= CNT_ONE;
            end else begin
                low_cnt_r <= (low_cnt_r != CNT_MAX) ? (low_cnt_r + CNT_ONE) : low_cnt_r;
            end
        end else begin
            low_cnt_r  <= low_cnt_r;
            idle_cnt_r <= (idle_cnt_r != CNT_MAX) ? (idle_cnt_r + CNT_ONE) : idle_cnt_r;
        end
    end

    assign fall_edge    = fall_r;
    assign bit_valid    = rise_r;
    assign bit_val      = bit_val_r;
    assign low_too_long = ~sync2_r & (low_cnt_r >= LOW_TICKS);
    assign idle_hit     = sync2_r & (idle_cnt_r >= IDLE_LAST);

endmodule

// File: rtl/n64_cmd_rx.sv
// Console-side N64 command receiver: decodes command frames into the reply-select
// code and holds it while the reply transmitter is busy.
module n64_cmd_rx
    import n64_pkg::*;
#(
    parameter int CLKS_PER_US = 48,
    parameter int ONE_MAX_US  = 2,
    parameter int LOW_MAX_US  = 5,
    parameter int IDLE_US     = 4,
    parameter int WDOG_US     = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        n64_in,
    input  logic        tx_busy,
    output logic [4:0]  Response,
    output logic [7:0]  cmd,
    output logic [15:0] pak_addr,
    output logic        frame_err
);

    localparam int              CW       = $clog2(WDOG_US * CLKS_PER_US + 1);
    localparam logic [CW-1:0]   WD_LAST  = CW'(WDOG_US * CLKS_PER_US - 1);
    localparam logic [CW-1:0]   WD_ONE   = CW'(1);
    localparam logic [8:0]      BITS_MAX = 9'h1FF;

    logic fall_edge_s, bit_valid_s, bit_val_s, low_too_long_s, idle_hit_s;

    n64_bit_sampler #(
        .CLKS_PER_US (CLKS_PER_US),
        .ONE_MAX_US  (ONE_MAX_US),
        .LOW_MAX_US  (LOW_MAX_US),
        .IDLE_US     (IDLE_US),
        .CW          (CW)
    ) u_sampler (
        .clk          (clk),
        .reset        (reset),
        .n64_in       (n64_in),
        .fall_edge    (fall_edge_s),
        .bit_valid    (bit_valid_s),
        .bit_val      (bit_val_s),
        .low_too_long (low_too_long_s),
        .idle_hit     (idle_hit_s)
    );

    rx_state_t     state_r, state_n;
    logic [4:0]    resp_r, resp_n;
    logic [7:0]    cmd_r, cmd_n;
    logic [15:0]   addr_r, addr_n;
    logic          err_r, err_n;
    logic [7:0]    cmd_sh_r, cmd_sh_n;
    logic [15:0]   addr_sh_r, addr_sh_n;
    logic [8:0]    bitcnt_r, bitcnt_n;
    logic [CW-1:0] wd_r, wd_n;
    logic          seen_r, seen_n;
    logic [4:0]    class_s;

    assign class_s = classify(bitcnt_r, cmd_sh_r, addr_sh_r[15:5]);

    // Frame FSM: next state, field shifting and registered-output updates.
    always_comb begin
        state_n   = state_r;
        resp_n    = resp_r;
        cmd_n     = cmd_r;
        addr_n    = addr_r;
        err_n     = 1'b0;
        cmd_sh_n  = cmd_sh_r;
        addr_sh_n = addr_sh_r;
        bitcnt_n  = bitcnt_r;
        wd_n      = wd_r;
        seen_n    = seen_r;
        case (state_r)
            ST_IDLE: begin
                if (fall_edge_s) begin
                    state_n   = ST_RX;
                    bitcnt_n  = 9'd0;
                    cmd_sh_n  = 8'h00;
                    addr_sh_n = 16'h0000;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_RX: begin
                // Idle expiry is checked first so it closes the frame ahead of any new edge.
                if (idle_hit_s) begin
                    if (class_s != RESP_IDLE) begin
                        state_n = ST_HOLD;
                        resp_n  = class_s;
                        cmd_n   = cmd_sh_r;
                        wd_n    = {CW{1'b0}};
                        seen_n  = tx_busy;
                        if ((cmd_sh_r == CMD_RDPAK) || (cmd_sh_r == CMD_WRPAK)) begin
                            addr_n = addr_sh_r;
                        end else begin
                            addr_n = addr_r;
                        end
                    end else begin
                        state_n = ST_ERR;
                        err_n   = 1'b1;
                    end
                end else if (low_too_long_s || (bitcnt_r > BITS_WRPAK)) begin
                    state_n = ST_ERR;
                    err_n   = 1'b1;
                end else if (bit_valid_s) begin
                    bitcnt_n = (bitcnt_r != BITS_MAX) ? (bitcnt_r + 9'd1) : bitcnt_r;
                    if (bitcnt_r < 9'd8) begin
                        cmd_sh_n = {cmd_sh_r[6:0], bit_val_s};
                    end else if (bitcnt_r < 9'd24) begin
                        addr_sh_n = {addr_sh_r[14:0], bit_val_s};
                    end else begin
                        addr_sh_n = addr_sh_r;
                    end
                end else begin
                    state_n = ST_RX;
                end
            end
            ST_HOLD: begin
                seen_n = seen_r | tx_busy;
                if ((seen_r && !tx_busy) || (wd_r >= WD_LAST)) begin
                    state_n = ST_IDLE;
                    resp_n  = RESP_IDLE;
                end else begin
                    wd_n = wd_r + WD_ONE;
                end
            end
            ST_ERR: begin
                if (idle_hit_s) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_ERR;
                end
            end
            default: begin
                state_n = ST_IDLE;
                resp_n  = RESP_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            resp_r    <= RESP_IDLE;
            cmd_r     <= 8'h00;
            addr_r    <= 16'h0000;
            err_r     <= 1'b0;
            cmd_sh_r  <= 8'h00;
            addr_sh_r <= 16'h0000;
            bitcnt_r  <= 9'd0;
            wd_r      <= {CW{1'b0}};
            seen_r    <= 1'b0;
        end else begin
            state_r   <= state_n;
            resp_r    <= resp_n;
            cmd_r     <= cmd_n;
            addr_r    <= addr_n;
            err_r     <= err_n;
            cmd_sh_r  <= cmd_sh_n;
            addr_sh_r <= addr_sh_n;
            bitcnt_r  <= bitcnt_n;
            wd_r      <= wd_n;
            seen_r    <= seen_n;
        end
    end

    assign Response  = resp_r;
    assign cmd       = cmd_r;
    assign pak_addr  = addr_r;
    assign frame_err = err_r;

endmodule

// File: tb/tb_n64_cmd_rx.sv
// Scoreboard bench for n64_cmd_rx: stimulus pushes expected Response/frame_err events,
// a forked monitor pops and compares them whenever the DUT presents one.
module tb_n64_cmd_rx;

    typedef struct {
        bit          is_err;
        logic [4:0]  resp;
        logic [7:0]  cmd;
        logic [15:0] addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        n64_in;
    logic        tx_busy;
    logic [4:0]  Response;
    logic [7:0]  cmd;
    logic [15:0] pak_addr;
    logic        frame_err;

    int          checks = 0;
    int          failures = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [4:0]  prev_resp;
    int          lat;
    int          hold_cyc;

    always #5 clk = ~clk;

    n64_cmd_rx #(.CLKS_PER_US(48)) dut (
        .clk       (clk),
        .reset     (reset),
        .n64_in    (n64_in),
        .tx_busy   (tx_busy),
        .Response  (Response),
        .cmd       (cmd),
        .pak_addr  (pak_addr),
        .frame_err (frame_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_evt(input bit is_err, input logic [4:0] r, input logic [7:0] c,
                            input logic [15:0] a);
        exp_t e;
        e.is_err = is_err;
        e.resp   = r;
        e.cmd    = c;
        e.addr   = a;
        exp_q.push_back(e);
    endtask

    // 1 = 1us low; 0 = 3us low. Fast bits shorten the high time and the 0 low (still >= 2us).
    task automatic send_bit(input bit b, input bit fast);
        int lo, hi;
        lo = b ? 48 : (fast ? 100 : 144);
        hi = b ? (fast ? 12 : 144) : (fast ? 12 : 48);
        n64_in = 1'b0;
        repeat (lo) @(negedge clk);
        n64_in = 1'b1;
        repeat (hi) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit fast);
        for (int i = 7; i >= 0; i--) send_bit(b[i], fast);
    endtask

    task automatic send_stop();
        n64_in = 1'b0;
        repeat (48) @(negedge clk);
        n64_in = 1'b1;
    endtask

    task automatic wait_resp(input string name, output int cyc);
        cyc = 0;
        while (Response == 5'b00000 && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk(name, {31'd0, (Response != 5'b00000)}, 32'd1);
    endtask

    task automatic clear_resp(input string name);
        int cyc;
        tx_busy = 1'b1;
        repeat (10) @(negedge clk);
        tx_busy = 1'b0;
        cyc = 0;
        while (Response != 5'b00000 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk(name, {27'd0, Response}, 32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        n64_in  = 1'b1;
        tx_busy = 1'b0;
        prev_resp = 5'b00000;
        repeat (4) @(negedge clk);
        chk("reset_response", {27'd0, Response}, 32'd0);
        chk("reset_cmd", {24'd0, cmd}, 32'd0);
        chk("reset_pak_addr", {16'd0, pak_addr}, 32'd0);
        chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
        reset = 1'b0;
        repeat (300) @(negedge clk);

        fork
            forever begin
                @(negedge clk);
                if (frame_err === 1'b1) begin
                    chk("sb_has_entry_err", {31'd0, (exp_q.size() != 0)}, 32'd1);
                    if (exp_q.size() != 0) begin
                        mon_e = exp_q.pop_front();
                        chk("sb_kind_err", {31'd0, mon_e.is_err}, 32'd1);
                    end
                end
                if (Response !== prev_resp) begin
                    prev_resp = Response;
                    chk("sb_has_entry_resp", {31'd0, (exp_q.size() != 0)}, 32'd1);
                    if (exp_q.size() != 0) begin
                        mon_e = exp_q.pop_front();
                        chk("sb_kind_resp", {31'd0, mon_e.is_err}, 32'd0);
                        chk("sb_response", {27'd0, Response}, {27'd0, mon_e.resp});
                        chk("sb_cmd", {24'd0, cmd}, {24'd0, mon_e.cmd});
                        chk("sb_pak_addr", {16'd0, pak_addr}, {16'd0, mon_e.addr});
                    end
                end
            end
        join_none

        // Poll with latency measured from the stop bit's rising edge
        push_evt(1'b0, 5'b10001, 8'h01, 16'h0000);
        send_byte(8'h01, 1'b0);
        send_stop();
        wait_resp("poll_resp_timeout", lat);
        chk("poll_latency", {31'd0, (lat >= 190 && lat <= 195)}, 32'd1);
        push_evt(1'b0, 5'b00000, 8'h01, 16'h0000);
        clear_resp("poll_clear");

        // Read pak at 0x8000, held through 100us of tx_busy
        push_evt(1'b0, 5'b10101, 8'h02, 16'h8001);
        send_byte(8'h02, 1'b0);
        send_byte(8'h80, 1'b0);
        send_byte(8'h01, 1'b0);
        send_stop();
        wait_resp("rdpak_resp_timeout", lat);
        tx_busy = 1'b1;
        repeat (4800) @(negedge clk);
        chk("rdpak_held_while_busy", {27'd0, Response}, 32'h15);
        push_evt(1'b0, 5'b00000, 8'h02, 16'h8001);
        tx_busy = 1'b0;
        @(negedge clk);
        chk("rdpak_clear_next_cycle", {27'd0, Response}, 32'd0);
        repeat (300) @(negedge clk);

        // Write pak: 281-bit frame, then line toggles during HOLD
        push_evt(1'b0, 5'b10111, 8'h03, 16'hC01B);
        send_byte(8'h03, 1'b0);
        send_byte(8'hC0, 1'b0);
        send_byte(8'h1B, 1'b0);
        for (int k = 0; k < 32; k++) send_byte(8'h80, 1'b1);
        send_stop();
        wait_resp("wrpak_resp_timeout", lat);
        repeat (5) begin
            n64_in = 1'b0;
            repeat (48) @(negedge clk);
            n64_in = 1'b1;
            repeat (48) @(negedge clk);
        end
        chk("wrpak_hold_ignores_line", {27'd0, Response}, 32'h17);
        chk("wrpak_addr_after_toggles", {16'd0, pak_addr}, 32'hC01B);
        push_evt(1'b0, 5'b00000, 8'h03, 16'hC01B);
        clear_resp("wrpak_clear");
        repeat (300) @(negedge clk);

        // 0x01 whose first bit is a 6us low: error, then a clean 0xFF frame
        push_evt(1'b1, 5'b00000, 8'h00, 16'h0000);
        n64_in = 1'b0;
        repeat (288) @(negedge clk);
        n64_in = 1'b1;
        repeat (48) @(negedge clk);
        for (int k = 0; k < 6; k++) send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_stop();
        repeat (300) @(negedge clk);
        chk("longlow_no_resp", {27'd0, Response}, 32'd0);
        push_evt(1'b0, 5'b10010, 8'hFF, 16'hC01B);
        send_byte(8'hFF, 1'b0);
        send_stop();
        wait_resp("reset_cmd_resp_timeout", lat);
        push_evt(1'b0, 5'b00000, 8'hFF, 16'hC01B);
        clear_resp("reset_cmd_clear");
        repeat (300) @(negedge clk);

        // 12-bit frame
        push_evt(1'b1, 5'b00000, 8'h00, 16'h0000);
        send_byte(8'h01, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_stop();
        repeat (300) @(negedge clk);
        chk("short_frame_no_resp", {27'd0, Response}, 32'd0);

        // Watchdog: status reply never taken by the transmitter
        push_evt(1'b0, 5'b10010, 8'h00, 16'hC01B);
        send_byte(8'h00, 1'b0);
        send_stop();
        wait_resp("wdog_resp_timeout", lat);
        push_evt(1'b0, 5'b00000, 8'h00, 16'hC01B);
        hold_cyc = 0;
        while (Response != 5'b00000 && hold_cyc < 30000) begin
            @(negedge clk);
            hold_cyc++;
        end
        chk("wdog_hold_cycles", {31'd0, (hold_cyc >= 23999 && hold_cyc <= 24001)}, 32'd1);
        repeat (300) @(negedge clk);

        // Reset after 5 bits of a 0x02 frame, then a clean status frame
        for (int k = 0; k < 5; k++) send_bit(1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("midframe_reset_response", {27'd0, Response}, 32'd0);
        chk("midframe_reset_cmd", {24'd0, cmd}, 32'd0);
        chk("midframe_reset_pak_addr", {16'd0, pak_addr}, 32'd0);
        chk("midframe_reset_frame_err", {31'd0, frame_err}, 32'd0);
        reset = 1'b0;
        repeat (300) @(negedge clk);
        push_evt(1'b0, 5'b10010, 8'h00, 16'h0000);
        send_byte(8'h00, 1'b0);
        send_stop();
        wait_resp("post_reset_resp_timeout", lat);
        push_evt(1'b0, 5'b00000, 8'h00, 16'h0000);
        clear_resp("post_reset_clear");

        repeat (50) @(negedge clk);
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
